// File: rtl/skid_buffer_pkg.sv
// Shared definitions for the skid_buffer stage.
//   COUNT_W : width of the occupancy count / state register
//   state_e : occupancy state encoding; the unused code 2'd3 recovers to EMPTY
package skid_buffer_pkg;

    localparam int COUNT_W = 2;

    typedef enum logic [COUNT_W-1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/dff_en.sv
// Flop library cell: WIDTH-bit enable flop, synchronous active-low reset to 0.
//   clk   : rising-edge clock
//   rst_n : synchronous reset, active-low (overrides en)
//   en    : load d when high, otherwise hold
//   d / q : next / current value
module dff_en #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dff_en_rstval.sv
// Flop library cell: WIDTH-bit enable flop, synchronous active-low reset to RSTVAL.
//   clk   : rising-edge clock
//   rst_n : synchronous reset, active-low (overrides en)
//   en    : load d when high, otherwise hold
//   d / q : next / current value
module dff_en_rstval #(
    parameter int                WIDTH  = 1,
    parameter logic [WIDTH-1:0]  RSTVAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= RSTVAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dff_rstval.sv
// Flop library cell: WIDTH-bit register, synchronous active-low reset to RSTVAL.
//   clk   : rising-edge clock
//   rst_n : synchronous reset, active-low
//   d / q : next / current value
module dff_rstval #(
    parameter int                WIDTH  = 1,
    parameter logic [WIDTH-1:0]  RSTVAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= RSTVAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer. Registers data/valid towards the
// downstream side and absorbs one extra beat when downstream stalls, so
// s_ready depends only on local state (no combinational ready chain).
//   clk, rst_n        : clock, synchronous active-low reset
//   s_valid/s_ready/s_data : upstream handshake and data
//   m_valid/m_ready/m_data : downstream handshake and data
//   count             : occupancy 0..2
module skid_buffer
    import skid_buffer_pkg::*;
#(
    parameter int                WIDTH  = 8,
    parameter logic [WIDTH-1:0]  RSTVAL = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [WIDTH-1:0]   s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [WIDTH-1:0]   m_data,
    output logic [COUNT_W-1:0] count
);

    logic [COUNT_W-1:0] state_raw;
    state_e             state_q;
    state_e             state_d;
    logic [WIDTH-1:0]   main_q;
    logic [WIDTH-1:0]   main_d;
    logic               main_en;
    logic [WIDTH-1:0]   skid_q;
    logic [WIDTH-1:0]   skid_d;
    logic               skid_en;
    logic               acc_in;
    logic               acc_out;

    assign state_q = state_e'(state_raw);

    // Outputs come from registered state only.
    assign s_ready = (state_q != ST_FULL);
    assign m_valid = (state_q != ST_EMPTY);
    assign m_data  = main_q;

    assign acc_in  = s_valid & s_ready;
    assign acc_out = m_valid & m_ready;

    // The skid register only ever captures the incoming beat.
    assign skid_d  = s_data;

    always_comb begin
        state_d = state_q;
        main_d  = s_data;
        main_en = 1'b0;
        skid_en = 1'b0;
        count   = 2'd0;
        case (state_q)
            ST_EMPTY: begin
                count = 2'd0;
                if (acc_in) begin
                    state_d = ST_BUSY;
                    main_en = 1'b1;
                end
            end
            ST_BUSY: begin
                count = 2'd1;
                if (acc_in && acc_out) begin
                    main_en = 1'b1;
                end else if (acc_in) begin
                    state_d = ST_FULL;
                    skid_en = 1'b1;
                end else if (acc_out) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                count = 2'd2;
                // Skid beat moves up behind the departing main beat.
                if (acc_out) begin
                    state_d = ST_BUSY;
                    main_d  = skid_q;
                    main_en = 1'b1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Register stage: state, main (output) and skid storage.
    dff_rstval #(
        .WIDTH  (COUNT_W),
        .RSTVAL (ST_EMPTY)
    ) u_state (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (state_d),
        .q     (state_raw)
    );

    dff_en_rstval #(
        .WIDTH  (WIDTH),
        .RSTVAL (RSTVAL)
    ) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (main_en),
        .d     (main_d),
        .q     (main_q)
    );

    dff_en #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (skid_en),
        .d     (skid_d),
        .q     (skid_q)
    );

endmodule

// File: tb/tb_skid_buffer.sv
module tb_skid_buffer;

    localparam int         WIDTH  = 8;
    localparam logic [7:0] RSTVAL = 8'h5A;

    logic             clk;
    logic             rst_n;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [1:0]       count;

    int               n_checks;
    int               n_fail;
    logic [WIDTH-1:0] sb[$];

    skid_buffer #(
        .WIDTH  (WIDTH),
        .RSTVAL (RSTVAL)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: handshakes are resolved at the negedge, ahead of the edge that commits them.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (m_valid && m_ready) begin
                check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    check("sb_data", 32'(m_data), 32'(sb[0]));
                    void'(sb.pop_front());
                end
            end
            if (s_valid && s_ready) begin
                sb.push_back(s_data);
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        s_valid  = 1'b1;
        s_data   = 8'hAA;
        m_ready  = 1'b0;

        // Reset with active inputs
        tick();
        tick();
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data",  32'(m_data),  32'(RSTVAL));
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_count",   32'(count),   32'd0);

        // First beat after release
        rst_n   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h77;
        tick();
        check("first_m_valid", 32'(m_valid), 32'd1);
        check("first_m_data",  32'(m_data),  32'h77);
        check("first_count",   32'(count),   32'd1);
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        check("first_drain_count", 32'(count), 32'd0);

        // Streaming at full rate
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(i);
            check("stream_s_ready", 32'(s_ready), 32'd1);
            tick();
            check("stream_m_data", 32'(m_data), 32'(i));
            check("stream_count",  32'(count),  32'd1);
        end
        s_valid = 1'b0;
        tick();
        check("stream_end_count", 32'(count), 32'd0);

        // Stall fill
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h11;
        tick();
        s_data  = 8'h22;
        tick();
        s_data  = 8'h33;
        check("fill_count",   32'(count),   32'd2);
        check("fill_s_ready", 32'(s_ready), 32'd0);
        check("fill_m_data",  32'(m_data),  32'h11);

        // Hold while full with noisy upstream data
        for (int i = 0; i < 5; i++) begin
            s_data = 8'($urandom);
            tick();
            check("hold_m_data",  32'(m_data),  32'h11);
            check("hold_m_valid", 32'(m_valid), 32'd1);
            check("hold_count",   32'(count),   32'd2);
        end

        // Release: 11, 22, 33 in order
        s_data  = 8'h33;
        m_ready = 1'b1;
        tick();
        check("drain_m_data_22", 32'(m_data), 32'h22);
        check("drain_count_1",   32'(count),  32'd1);
        tick();
        check("drain_m_data_33", 32'(m_data), 32'h33);
        s_valid = 1'b0;
        tick();
        check("drain_count_0", 32'(count), 32'd0);

        // Simultaneous in/out in BUSY
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h40;
        tick();
        check("busy_m_data_40", 32'(m_data), 32'h40);
        s_data  = 8'h41;
        m_ready = 1'b1;
        tick();
        check("busy_m_data_41", 32'(m_data), 32'h41);
        check("busy_count",     32'(count),  32'd1);
        s_valid = 1'b0;
        tick();

        // Reset while full: C0/C1 must never emerge
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'hC0;
        tick();
        s_data  = 8'hC1;
        tick();
        check("midrst_full_count", 32'(count), 32'd2);
        s_valid = 1'b0;
        rst_n   = 1'b0;
        tick();
        check("midrst_m_valid", 32'(m_valid), 32'd0);
        check("midrst_count",   32'(count),   32'd0);
        check("midrst_m_data",  32'(m_data),  32'(RSTVAL));
        check("midrst_s_ready", 32'(s_ready), 32'd1);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_quiet", 32'(m_valid), 32'd0);
        end

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            m_ready = ($urandom_range(0, 3) != 0);
            s_data  = 8'($urandom);
            tick();
            check("rand_count_vs_sb", 32'(count), 32'(sb.size()));
        end

        // Bounded drain
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            tick();
        end
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        check("final_m_valid",  32'(m_valid),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/skid_buffer.md
Name: skid_buffer

Overview:
- Two-entry valid/ready pipeline register stage placed between dff-based datapath stages.
- Registers the forward path (data and valid) and absorbs one beat when downstream stalls.
- Sustains 1 beat/cycle throughput; breaks the combinational ready path between neighbouring stages.
- Built on the team's enable-flop library cells.

Parameters:
WIDTH, 8, data width in bits
RSTVAL, 0, reset value of the output data register (m_data)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous reset, active-low
s_valid  input  1  upstream beat valid
s_ready  output  1  stage can accept a beat this cycle
s_data  input  WIDTH  upstream data
m_valid  output  1  downstream beat valid
m_ready  input  1  downstream accepts beat
m_data  output  WIDTH  downstream data
count  output  2  occupancy 0..2

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk. On a clk edge with rst_n=0: state=EMPTY, main data=RSTVAL, skid data=0. Resulting outputs: m_valid=0, m_data=RSTVAL, s_ready=1, count=0. Inputs are ignored during reset.
- Reset mid-operation: any held beats are discarded with no output handshake. The first accept is possible on the first edge with rst_n=1.
- Handshake definitions: acc_in = s_valid & s_ready; acc_out = m_valid & m_ready. A transfer occurs on the rising edge when the handshake is true.
- Outputs decoded from registered state only, with no combinational input-to-output path:
  - s_ready = (state != FULL)
  - m_valid = (state != EMPTY)
  - m_data = main register
  - count = 0/1/2 for EMPTY/BUSY/FULL
- States: EMPTY, BUSY (main holds one beat), FULL (main and skid both hold beats).
- EMPTY: acc_in -> BUSY, main <= s_data. Otherwise stay in EMPTY.
- BUSY:
  - acc_in & acc_out -> BUSY, main <= s_data (pass-through at full rate).
  - acc_in & !acc_out -> FULL, skid <= s_data.
  - !acc_in & acc_out -> EMPTY.
  - Otherwise hold.
- FULL: s_ready=0, so s_valid is ignored.
  - acc_out -> BUSY, main <= skid.
  - Otherwise hold.
- Latency: a beat accepted at edge N shows m_valid=1 with its data after edge N. Minimum latency is 1 cycle. With continuous m_ready=1 and s_valid=1, throughput is 1 beat/cycle.
- Ordering: strict FIFO. The skid beat always exits after the main beat.
- Stability: while m_valid=1 and m_ready=0, m_data and m_valid are held unchanged.
- Data registers are written only on their enable conditions above, and otherwise retain their value. After EMPTY, main keeps its last value (not cleared).
- s_data/s_valid X while s_ready=0 or s_valid=0 must not corrupt state.

Decomposition:
- Shared package holds:
  - state encoding constants: ST_EMPTY=2'd0, ST_BUSY=2'd1, ST_FULL=2'd2; 2'd3 is illegal and recovers to EMPTY.
  - COUNT_W=2.
- Sub-module: the existing dff_en library cell, instantiated twice:
  - main: WIDTH bits. Reset value must be RSTVAL, so main uses a local enable-with-reset-value variant, dff_en_rstval, added to the flop library.
  - skid: WIDTH bits, reset value 0.
- State register uses the existing dff_rstval with WIDTH=2, RSTVAL=ST_EMPTY.
- Next-state and enable logic stay in skid_buffer.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with s_valid=1, s_data=8'hAA, RSTVAL=8'h5A -> m_valid=0, m_data=8'h5A, s_ready=1, count=0. After release, the first beat appears one edge later.
- Streaming: m_ready=1; send 8'h01..8'h08 back-to-back -> m_data 01..08 on consecutive cycles, each 1 cycle after acceptance, with s_ready=1 throughout and count=1.
- Stall fill: m_ready=0; send 8'h11, 8'h22, 8'h33 -> 11 and 22 accepted, count=2, s_ready=0, 33 held upstream. Raise m_ready -> output 11, 22, 33 in order with no loss or duplicate.
- Hold stability: FULL with m_ready=0 for 5 cycles while s_data toggles randomly -> m_data stays 11, count stays 2.
- Simultaneous in/out in BUSY: main=8'h40, s_valid=1 with 8'h41, m_ready=1 -> next cycle m_data=8'h41, count=1.
- Reset mid-operation: FULL with 8'hC0/8'hC1, assert rst_n=0 for 1 edge -> m_valid=0, count=0, m_data=RSTVAL. Neither C0 nor C1 is ever emitted.
